fios_result_collector: RTL and testbench

FIOS_RESULT_COLLECTOR -- requirements
Module: fios_result_collector

---
 rtl/fios_result_collector_if.sv | 43 ++++
 rtl/fios_result_collector.sv | 125 ++++++++++++
 tb/tb_fios_result_collector.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fios_result_collector_if.sv
// fios_result_collector_if
//   Bundles the collector's handshake and data signals.
//   slave  : the collector itself (consumes issue/P, produces words).
//   master : the surrounding logic (upstream DSP control and word consumer).
//   Signals:
//     start_i, issue_i, P_i[33:0]     upstream control and DSP P output
//     stall_o                         back-pressure to upstream issue logic
//     word_o[16:0], word_valid_o,     result word stream with ready/valid
//     word_ready_i, last_o
//     carry_o[16:0]                   upper half of last captured P
//     busy_o                          operand in progress
//     ovf_o                           sticky overflow, only with FIOS_COLLECT_OVF_EN
interface fios_result_collector_if;
  logic        start_i;
  logic        issue_i;
  logic [33:0] P_i;
  logic        stall_o;
  logic [16:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        last_o;
  logic [16:0] carry_o;
  logic        busy_o;
`ifdef FIOS_COLLECT_OVF_EN
  logic        ovf_o;
`endif

  modport slave (
`ifdef FIOS_COLLECT_OVF_EN
    output ovf_o,
`endif
    input  start_i, issue_i, P_i, word_ready_i,
    output stall_o, word_o, word_valid_o, last_o, carry_o, busy_o
  );

  modport master (
`ifdef FIOS_COLLECT_OVF_EN
    input  ovf_o,
`endif
    output start_i, issue_i, P_i, word_ready_i,
    input  stall_o, word_o, word_valid_o, last_o, carry_o, busy_o
  );
endinterface

// File: rtl/fios_result_collector.sv
// fios_result_collector
//   Collects the low 17 bits of each DSP P result into a small word FIFO,
//   tags the final word of each operand, and feeds the upper 17 bits back
//   as carry. An issue is tracked through a LATENCY-deep valid pipe so the
//   P output is captured exactly when the DSP presents it.
//   Ports:
//     clock_i    rising-edge clock
//     reset_n_i  asynchronous active-low reset
//     bus        fios_result_collector_if.slave (see interface header)
//   Optional feature: define FIOS_COLLECT_OVF_EN to add the sticky ovf_o flag.
module fios_result_collector #(
  parameter int ABREG      = 1,
  parameter int MREG       = 1,
  parameter int WORD_COUNT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  fios_result_collector_if.slave    bus
);
  localparam int LATENCY = 1 + ABREG + MREG;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int CNT_W   = $clog2(WORD_COUNT);
  localparam int SUM_W   = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t             state, state_n;
  logic [LATENCY-1:0] vld_p;
  logic [CNT_W-1:0]   word_cnt;
  logic [OCC_W-1:0]   wr_ptr, rd_ptr, occ;
  logic [17:0]        mem [FIFO_DEPTH];
  logic [16:0]        carry_q;
  logic [SUM_W-1:0]   inflight;

  logic cap, cap_ok, last_tag, accept_start;
  logic empty, full, push, pop, head_last;

  assign cap          = vld_p[LATENCY-1];
  assign cap_ok       = cap && (state == COLLECT);
  assign last_tag     = (word_cnt == CNT_W'(WORD_COUNT - 1));
  assign accept_start = bus.start_i && (state == IDLE);

  assign occ       = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (occ == OCC_W'(FIFO_DEPTH));
  assign pop       = !empty && bus.word_ready_i;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push      = cap_ok && (!full || pop);
  assign head_last = mem[rd_ptr[PTR_W-1:0]][17];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + SUM_W'(vld_p[i]);
  end

  assign bus.stall_o      = (SUM_W'(occ) + inflight) >= SUM_W'(FIFO_DEPTH - 1);
  assign bus.word_valid_o = !empty;
  assign bus.word_o       = mem[rd_ptr[PTR_W-1:0]][16:0];
  assign bus.last_o       = !empty && head_last;
  assign bus.carry_o      = carry_q;
  assign bus.busy_o       = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start_i) state_n = COLLECT;
      COLLECT: if (cap && last_tag) state_n = DRAIN;
      // An empty FIFO here means the tagged word was dropped; leave anyway
      // rather than wait for a word that will never arrive.
      DRAIN:   if ((pop && head_last) || empty) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Issue-to-capture valid pipe
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= bus.issue_i;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Capture stage: control state, counter, pointers, carry
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      word_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      carry_q  <= '0;
    end else begin
      state <= state_n;
      if (accept_start)
        word_cnt <= '0;
      else if (cap_ok)
        word_cnt <= last_tag ? '0 : word_cnt + 1'b1;
      if (cap_ok) carry_q <= bus.P_i[33:17];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {last_tag, bus.P_i[16:0]};
  end

`ifdef FIOS_COLLECT_OVF_EN
  logic ovf_q, drop;
  assign drop      = cap_ok && full && !pop;
  assign bus.ovf_o = ovf_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)
      ovf_q <= 1'b0;
    else if (accept_start)
      ovf_q <= 1'b0;
    else if (drop || (cap_ok && last_tag && (bus.P_i[33:17] != 17'd0)))
      ovf_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_fios_result_collector.sv
// tb_fios_result_collector
//   Directed bench for fios_result_collector. Two instances share stimulus:
//   u_a (WORD_COUNT=4) and u_b (WORD_COUNT=8), both LATENCY=3, FIFO_DEPTH=4.
//   A small delay line presents each issued value on P at its capture cycle.
module tb_fios_result_collector;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, issue, ready;
  logic [33:0] p;
  logic [33:0] pend [0:LAT];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  fios_result_collector_if if_a ();
  fios_result_collector_if if_b ();

  assign if_a.start_i      = start;
  assign if_a.issue_i      = issue;
  assign if_a.P_i          = p;
  assign if_a.word_ready_i = ready;
  assign if_b.start_i      = start;
  assign if_b.issue_i      = issue;
  assign if_b.P_i          = p;
  assign if_b.word_ready_i = ready;

  fios_result_collector #(.ABREG(1), .MREG(1), .WORD_COUNT(4), .FIFO_DEPTH(4)) u_a (
    .clock_i(clk), .reset_n_i(rst_n), .bus(if_a));
  fios_result_collector #(.ABREG(1), .MREG(1), .WORD_COUNT(8), .FIFO_DEPTH(4)) u_b (
    .clock_i(clk), .reset_n_i(rst_n), .bus(if_b));

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i <= LAT; i++) pend[i] = '0;
    p = '0;
  endtask

  // One clock: apply start/issue, advance the DSP delay line, sample at +1.
  task automatic step(input logic st, input logic iss, input logic [33:0] val);
    start = st;
    issue = iss;
    for (int i = LAT; i > 0; i--) pend[i] = pend[i-1];
    pend[0] = iss ? val : 34'd0;
    p = pend[LAT];
    @(posedge clk); #1;
    start = 1'b0;
    issue = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    issue = 1'b0;
    ready = 1'b0;
    clear_pend();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid_a", if_a.word_valid_o, 1'b0);
    chk("rst_last_a",  if_a.last_o,       1'b0);
    chk("rst_stall_a", if_a.stall_o,      1'b0);
    chk("rst_busy_a",  if_a.busy_o,       1'b0);
    chk("rst_carry_a", if_a.carry_o,      17'h0);
    chk("rst_busy_b",  if_b.busy_o,       1'b0);
`ifdef FIOS_COLLECT_OVF_EN
    chk("rst_ovf_a",   if_a.ovf_o,        1'b0);
`endif

    // Basic 4-word operand with a free-running consumer
    ready = 1'b1;
    step(1'b1, 1'b0, 34'd0);
    chk("t1_busy", if_a.busy_o, 1'b1);
    step(1'b0, 1'b1, 34'd1);
    step(1'b0, 1'b1, 34'd2);
    step(1'b0, 1'b1, 34'd3);
    chk("t1_empty_before_cap", if_a.word_valid_o, 1'b0);
    step(1'b0, 1'b1, 34'd4);
    chk("t1_w1_valid", if_a.word_valid_o, 1'b1);
    chk("t1_w1",       if_a.word_o,       17'd1);
    chk("t1_w1_last",  if_a.last_o,       1'b0);
    step(1'b0, 1'b0, 34'd0);
    chk("t1_w2",       if_a.word_o,       17'd2);
    chk("t1_w2_last",  if_a.last_o,       1'b0);
    step(1'b0, 1'b0, 34'd0);
    chk("t1_w3",       if_a.word_o,       17'd3);
    step(1'b0, 1'b0, 34'd0);
    chk("t1_w4",       if_a.word_o,       17'd4);
    chk("t1_w4_last",  if_a.last_o,       1'b1);
    chk("t1_w4_busy",  if_a.busy_o,       1'b1);
    step(1'b0, 1'b0, 34'd0);
    chk("t1_idle_busy",  if_a.busy_o,       1'b0);
    chk("t1_idle_valid", if_a.word_valid_o, 1'b0);

    // All-ones P splits into word and carry
    do_reset();
    step(1'b1, 1'b0, 34'd0);
    step(1'b0, 1'b1, 34'h3_FFFF_FFFF);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
    chk("t2_word",  if_a.word_o,  17'h1FFFF);
    chk("t2_carry", if_a.carry_o, 17'h1FFFF);
    chk("t2_last",  if_a.last_o,  1'b0);
`ifdef FIOS_COLLECT_OVF_EN
    chk("t2_ovf",   if_a.ovf_o,   1'b0);
`endif

    // Back-pressure, full FIFO, push+pop while full (u_b)
    do_reset();
    step(1'b1, 1'b0, 34'd0);
    step(1'b0, 1'b1, 34'd11);
    step(1'b0, 1'b1, 34'd12);
    chk("t3_stall_2", if_b.stall_o, 1'b0);
    step(1'b0, 1'b1, 34'd13);
    chk("t3_stall_3", if_b.stall_o, 1'b1);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
    chk("t3_head11",    if_b.word_o,  17'd11);
    chk("t3_stall_buf", if_b.stall_o, 1'b1);
    step(1'b0, 1'b1, 34'd14);
    step(1'b0, 1'b1, 34'd15);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
    chk("t3_hold11", if_b.word_o, 17'd11);
    ready = 1'b1;
    step(1'b0, 1'b0, 34'd0);
    chk("t3_pop12",  if_b.word_o,  17'd12);
    chk("t3_full",   if_b.stall_o, 1'b1);
`ifdef FIOS_COLLECT_OVF_EN
    chk("t3_ovf",    if_b.ovf_o,   1'b0);
`endif
    step(1'b0, 1'b0, 34'd0);
    chk("t3_pop13",  if_b.word_o, 17'd13);
    step(1'b0, 1'b0, 34'd0);
    chk("t3_pop14",  if_b.word_o, 17'd14);
    step(1'b0, 1'b0, 34'd0);
    chk("t3_pop15",  if_b.word_o, 17'd15);
    step(1'b0, 1'b0, 34'd0);
    chk("t3_empty",  if_b.word_valid_o, 1'b0);

    // Forced issue into a full FIFO drops one word (u_b)
    do_reset();
    step(1'b1, 1'b0, 34'd0);
    step(1'b0, 1'b1, 34'd21);
    step(1'b0, 1'b1, 34'd22);
    step(1'b0, 1'b1, 34'd23);
    step(1'b0, 1'b1, 34'd24);
    step(1'b0, 1'b1, 34'd25);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
`ifdef FIOS_COLLECT_OVF_EN
    chk("t4_ovf",  if_b.ovf_o, 1'b1);
`endif
    chk("t4_head21", if_b.word_o, 17'd21);
    chk("t4_busy",   if_b.busy_o, 1'b1);
    ready = 1'b1;
    step(1'b0, 1'b0, 34'd0);
    chk("t4_pop22", if_b.word_o, 17'd22);
    step(1'b0, 1'b0, 34'd0);
    chk("t4_pop23", if_b.word_o, 17'd23);
    step(1'b0, 1'b0, 34'd0);
    chk("t4_pop24", if_b.word_o, 17'd24);
    step(1'b0, 1'b0, 34'd0);
    chk("t4_dropped", if_b.word_valid_o, 1'b0);

    // Reset mid-operand with two words buffered (u_a)
    do_reset();
    step(1'b1, 1'b0, 34'd0);
    step(1'b0, 1'b1, 34'd31);
    step(1'b0, 1'b1, 34'd32);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
    chk("t5_buf_valid", if_a.word_valid_o, 1'b1);
    chk("t5_buf_head",  if_a.word_o,       17'd31);
    rst_n = 1'b0;
    clear_pend();
    #1;
    chk("t5_rst_valid", if_a.word_valid_o, 1'b0);
    chk("t5_rst_busy",  if_a.busy_o,       1'b0);
    chk("t5_rst_stall", if_a.stall_o,      1'b0);
    chk("t5_rst_carry", if_a.carry_o,      17'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    step(1'b1, 1'b0, 34'd0);
    chk("t5_no_stale0", if_a.word_valid_o, 1'b0);
    step(1'b0, 1'b1, 34'd41);
    step(1'b0, 1'b0, 34'd0);
    step(1'b0, 1'b0, 34'd0);
    chk("t5_no_stale1", if_a.word_valid_o, 1'b0);
    step(1'b0, 1'b0, 34'd0);
    chk("t5_new_valid", if_a.word_valid_o, 1'b1);
    chk("t5_new_word",  if_a.word_o,       17'd41);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
